// File: rtl/morra_cinese_param_if.sv
// Morra Cinese game bus: player moves and match configuration into the
// controller core, live round/match results and counters back out.
//   primo, secondo : player moves (00 none, 01 sasso, 10 carta, 11 forbice)
//   cfg            : extra rounds beyond the minimum, taken at match start
//   manche         : last round result (00 none, 01 p1, 10 p2, 11 draw)
//   partita        : match result (00 running, 01 p1, 10 p2, 11 draw)
//   punti1/punti2  : rounds won by each player
//   giocate        : valid rounds played
//   attivo         : match in progress
interface morra_cinese_param_if #(
   parameter int CFG_W = 4,
   parameter int CNT_W = 5
);
   logic [1:0]       primo;
   logic [1:0]       secondo;
   logic [CFG_W-1:0] cfg;
   logic [1:0]       manche;
   logic [1:0]       partita;
   logic [CNT_W-1:0] punti1;
   logic [CNT_W-1:0] punti2;
   logic [CNT_W-1:0] giocate;
   logic             attivo;

   modport master (
      output primo, secondo, cfg,
      input  manche, partita, punti1, punti2, giocate, attivo
   );

   modport slave (
      input  primo, secondo, cfg,
      output manche, partita, punti1, punti2, giocate, attivo
   );
endinterface

// File: rtl/morra_cinese_param.sv
// Two-player Morra Cinese match controller with configurable match length,
// win margin and minimum round count. One round is evaluated per clock.
//   clk    : clock, all state on the rising edge
//   inizia : synchronous active-high reset / new-match start (samples cfg)
//   bus    : slave side of morra_cinese_param_if (moves in, results out)
//
// state | meaning
// IDLE  | no match since power-up; moves ignored, outputs 0
// GIOCO | match running, one round evaluated per edge
// FINE  | match decided; results held until inizia
module morra_cinese_param #(
   parameter int MIN_MANCHE = 4,
   parameter int LEAD       = 2,
   parameter int CFG_W      = 4,
   parameter int CNT_W      = 5,
   parameter int NO_REPEAT  = 1
) (
   input  logic                   clk,
   input  logic                   inizia,
   morra_cinese_param_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GIOCO = 2'd1,
      FINE  = 2'd2
   } state_t;

   typedef logic [CNT_W:0] wide_t;

   localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_MANCHE);
   localparam wide_t            LEAD_C = wide_t'(LEAD);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] max_q, max_d;
   logic [CNT_W-1:0] p1_q, p1_d;
   logic [CNT_W-1:0] p2_q, p2_d;
   logic [CNT_W-1:0] g_q, g_d;
   logic [1:0]       manche_q, manche_d;
   logic [1:0]       partita_q, partita_d;
   logic             mem_vld_q, mem_vld_d;
   logic             mem_p2_q, mem_p2_d;
   logic [1:0]       mem_mv_q, mem_mv_d;

   logic             rep_hit;
   logic             invalid;
   logic [1:0]       res;
   logic [CNT_W-1:0] p1_n, p2_n, g_n;
   logic             lead1, lead2;

   function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
      return (a == 2'b01 && b == 2'b11) ||
             (a == 2'b10 && b == 2'b01) ||
             (a == 2'b11 && b == 2'b10);
   endfunction

   // The last winner may not replay the move they won with.
   assign rep_hit = (NO_REPEAT != 0) && mem_vld_q &&
                    (mem_p2_q ? (bus.secondo == mem_mv_q) : (bus.primo == mem_mv_q));

   assign invalid = (bus.primo == 2'b00) || (bus.secondo == 2'b00) || rep_hit;

   assign res = (bus.primo == bus.secondo)    ? 2'b11 :
                beats(bus.primo, bus.secondo) ? 2'b01 : 2'b10;

   assign p1_n = p1_q + {{(CNT_W-1){1'b0}}, (res == 2'b01)};
   assign p2_n = p2_q + {{(CNT_W-1){1'b0}}, (res == 2'b10)};
   assign g_n  = g_q + {{(CNT_W-1){1'b0}}, 1'b1};

   // Extra headroom bit so adding LEAD never wraps.
   assign lead1 = {1'b0, p1_n} >= ({1'b0, p2_n} + LEAD_C);
   assign lead2 = {1'b0, p2_n} >= ({1'b0, p1_n} + LEAD_C);

   always_ff @(posedge clk) begin
      state_q   <= state_d;
      max_q     <= max_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      g_q       <= g_d;
      manche_q  <= manche_d;
      partita_q <= partita_d;
      mem_vld_q <= mem_vld_d;
      mem_p2_q  <= mem_p2_d;
      mem_mv_q  <= mem_mv_d;
   end

   always_comb begin
      state_d   = state_q;
      max_d     = max_q;
      p1_d      = p1_q;
      p2_d      = p2_q;
      g_d       = g_q;
      manche_d  = 2'b00;
      partita_d = partita_q;
      mem_vld_d = mem_vld_q;
      mem_p2_d  = mem_p2_q;
      mem_mv_d  = mem_mv_q;

      if (inizia) begin
         state_d   = GIOCO;
         max_d     = MIN_C + CNT_W'(bus.cfg);
         p1_d      = '0;
         p2_d      = '0;
         g_d       = '0;
         partita_d = 2'b00;
         mem_vld_d = 1'b0;
         mem_p2_d  = 1'b0;
         mem_mv_d  = 2'b00;
      end else begin
         case (state_q)
            GIOCO: begin
               if (!invalid) begin
                  manche_d = res;
                  p1_d     = p1_n;
                  p2_d     = p2_n;
                  g_d      = g_n;
                  // A draw leaves nobody barred from any move.
                  mem_vld_d = (res != 2'b11);
                  mem_p2_d  = (res == 2'b10);
                  mem_mv_d  = (res == 2'b10) ? bus.secondo : bus.primo;

                  if (g_n >= MIN_C && (lead1 || lead2)) begin
                     partita_d = lead1 ? 2'b01 : 2'b10;
                     state_d   = FINE;
                  end else if (g_n == max_q) begin
                     partita_d = (p1_n > p2_n) ? 2'b01 :
                                 (p2_n > p1_n) ? 2'b10 : 2'b11;
                     state_d   = FINE;
                  end
               end
            end
            FINE: begin
               // results held; manche already defaults to none
            end
            default: begin
               p1_d      = '0;
               p2_d      = '0;
               g_d       = '0;
               partita_d = 2'b00;
               mem_vld_d = 1'b0;
            end
         endcase
      end
   end

   assign bus.manche  = manche_q;
   assign bus.partita = partita_q;
   assign bus.punti1  = p1_q;
   assign bus.punti2  = p2_q;
   assign bus.giocate = g_q;
   assign bus.attivo  = (state_q == GIOCO);

endmodule

// File: tb/tb_morra_cinese_param.sv
module tb_morra_cinese_param;

   localparam int CFG_W = 4;
   localparam int CNT_W = 5;
   localparam int MINM  = 4;
   localparam int LEADV = 2;

   logic clk = 1'b0;
   logic inizia;
   always #5 clk = ~clk;

   morra_cinese_param_if #(.CFG_W(CFG_W), .CNT_W(CNT_W)) bus ();

   morra_cinese_param #(
      .MIN_MANCHE(MINM), .LEAD(LEADV), .CFG_W(CFG_W), .CNT_W(CNT_W), .NO_REPEAT(1)
   ) dut (
      .clk   (clk),
      .inizia(inizia),
      .bus   (bus.slave)
   );

   typedef struct {
      logic       ini;
      logic [1:0] p;
      logic [1:0] s;
      int         c;
      logic [1:0] man;
      logic [1:0] par;
      int         s1;
      int         s2;
      int         g;
      logic       att;
   } vec_t;

   vec_t vq[$];
   int total = 0;
   int bad   = 0;

   function automatic void add(input logic ini, input logic [1:0] p, input logic [1:0] s,
                               input int c, input logic [1:0] man, input logic [1:0] par,
                               input int s1, input int s2, input int g, input logic att);
      vec_t v;
      v.ini = ini; v.p = p; v.s = s; v.c = c;
      v.man = man; v.par = par; v.s1 = s1; v.s2 = s2; v.g = g; v.att = att;
      vq.push_back(v);
   endfunction

   // Drive inputs, take one edge, compare all outputs 1 time unit later.
   task automatic step_check(input string name, input logic ini, input logic [1:0] p,
                             input logic [1:0] s, input int c, input logic [1:0] man,
                             input logic [1:0] par, input int s1, input int s2,
                             input int g, input logic att);
      logic [19:0] got, exp;
      inizia      = ini;
      bus.primo   = p;
      bus.secondo = s;
      bus.cfg     = CFG_W'(c);
      @(posedge clk);
      #1;
      got = {bus.manche, bus.partita, bus.punti1, bus.punti2, bus.giocate, bus.attivo};
      exp = {man, par, CNT_W'(s1), CNT_W'(s2), CNT_W'(g), att};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got manche=%b partita=%b p1=%0d p2=%0d g=%0d att=%b, want manche=%b partita=%b p1=%0d p2=%0d g=%0d att=%b",
                  name, bus.manche, bus.partita, bus.punti1, bus.punti2, bus.giocate, bus.attivo,
                  man, par, s1, s2, g, att);
      end
   endtask

   // Reference model state, kept as plain integers.
   int  m_s1, m_s2, m_g, m_max, m_lw, m_lm;
   bit  m_act;
   logic [1:0] m_man, m_par;

   function automatic void model(input logic ini, input int p, input int s, input int c);
      int w;
      if (ini) begin
         m_act = 1; m_max = MINM + c; m_s1 = 0; m_s2 = 0; m_g = 0;
         m_man = 2'b00; m_par = 2'b00; m_lw = 0; m_lm = 0;
      end else if (!m_act) begin
         m_man = 2'b00;
      end else if (p == 0 || s == 0 || (m_lw == 1 && p == m_lm) || (m_lw == 2 && s == m_lm)) begin
         m_man = 2'b00;
      end else begin
         // 1 sasso, 2 carta, 3 forbice: a beats b when a is one step ahead mod 3
         if (p == s) w = 3;
         else if ((p - s + 3) % 3 == 1) w = 1;
         else w = 2;
         m_g++;
         if (w == 1) m_s1++;
         if (w == 2) m_s2++;
         m_lw = (w == 3) ? 0 : w;
         m_lm = (w == 1) ? p : s;
         m_man = 2'(w);
         if (m_g >= MINM && (m_s1 - m_s2 >= LEADV || m_s2 - m_s1 >= LEADV)) begin
            m_par = (m_s1 > m_s2) ? 2'b01 : 2'b10;
            m_act = 0;
         end else if (m_g == m_max) begin
            m_par = (m_s1 > m_s2) ? 2'b01 : (m_s2 > m_s1) ? 2'b10 : 2'b11;
            m_act = 0;
         end
      end
   endfunction

   initial begin
      inizia = 1'b0; bus.primo = 2'b00; bus.secondo = 2'b00; bus.cfg = '0;

      // Win by lead with no-repeat, then FINE hold
      add(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 1);
      add(0, 2'b01, 2'b11, 0, 2'b01, 2'b00, 1, 0, 1, 1);
      add(0, 2'b01, 2'b11, 0, 2'b00, 2'b00, 1, 0, 1, 1);
      add(0, 2'b10, 2'b01, 0, 2'b01, 2'b00, 2, 0, 2, 1);
      add(0, 2'b01, 2'b11, 0, 2'b01, 2'b00, 3, 0, 3, 1);
      add(0, 2'b10, 2'b01, 0, 2'b01, 2'b01, 4, 0, 4, 0);
      for (int i = 0; i < 3; i++) add(0, 2'b10, 2'b01, 0, 2'b00, 2'b01, 4, 0, 4, 0);
      // Max rounds reached with small lead, invalid moves mid-match
      add(1, 2'b10, 2'b01, 1, 2'b00, 2'b00, 0, 0, 0, 1);
      add(0, 2'b01, 2'b11, 0, 2'b01, 2'b00, 1, 0, 1, 1);
      add(0, 2'b10, 2'b11, 0, 2'b10, 2'b00, 1, 1, 2, 1);
      add(0, 2'b10, 2'b01, 0, 2'b01, 2'b00, 2, 1, 3, 1);
      add(0, 2'b01, 2'b10, 0, 2'b10, 2'b00, 2, 2, 4, 1);
      add(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2, 2, 4, 1);
      add(0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2, 2, 4, 1);
      add(0, 2'b01, 2'b11, 0, 2'b01, 2'b01, 3, 2, 5, 0);
      // All-draw match, max 7
      add(1, 2'b00, 2'b00, 3, 2'b00, 2'b00, 0, 0, 0, 1);
      for (int i = 1; i <= 6; i++) add(0, 2'b10, 2'b10, 0, 2'b11, 2'b00, 0, 0, i, 1);
      add(0, 2'b10, 2'b10, 0, 2'b11, 2'b11, 0, 0, 7, 0);
      // Restart mid-match with cfg=2, then prove max=6
      add(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 1);
      add(0, 2'b01, 2'b11, 0, 2'b01, 2'b00, 1, 0, 1, 1);
      add(0, 2'b10, 2'b01, 0, 2'b01, 2'b00, 2, 0, 2, 1);
      add(1, 2'b01, 2'b11, 2, 2'b00, 2'b00, 0, 0, 0, 1);
      add(0, 2'b10, 2'b01, 0, 2'b01, 2'b00, 1, 0, 1, 1);
      for (int i = 2; i <= 5; i++) add(0, 2'b11, 2'b11, 0, 2'b11, 2'b00, 1, 0, i, 1);
      add(0, 2'b11, 2'b11, 0, 2'b11, 2'b01, 1, 0, 6, 0);
      // FINE then restart returns attivo
      add(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 1);

      foreach (vq[i])
         step_check($sformatf("vec%0d", i), vq[i].ini, vq[i].p, vq[i].s, vq[i].c,
                    vq[i].man, vq[i].par, vq[i].s1, vq[i].s2, vq[i].g, vq[i].att);

      // Lead reached before the minimum round count must not end the match;
      // a draw clears the winner memory so sasso may be replayed.
      step_check("early_ini", 1, 2'b00, 2'b00, 15, 2'b00, 2'b00, 0, 0, 0, 1);
      step_check("early_r1",  0, 2'b01, 2'b11, 0, 2'b01, 2'b00, 1, 0, 1, 1);
      step_check("early_r2",  0, 2'b10, 2'b01, 0, 2'b01, 2'b00, 2, 0, 2, 1);
      step_check("early_r3",  0, 2'b01, 2'b11, 0, 2'b01, 2'b00, 3, 0, 3, 1);
      step_check("early_rep", 0, 2'b01, 2'b10, 0, 2'b00, 2'b00, 3, 0, 3, 1);
      step_check("early_drw", 0, 2'b11, 2'b11, 0, 2'b11, 2'b01, 3, 0, 4, 0);
      // p2 no-repeat
      step_check("p2_ini",  1, 2'b00, 2'b00, 4, 2'b00, 2'b00, 0, 0, 0, 1);
      step_check("p2_win",  0, 2'b11, 2'b01, 0, 2'b10, 2'b00, 0, 1, 1, 1);
      step_check("p2_rep",  0, 2'b11, 2'b01, 0, 2'b00, 2'b00, 0, 1, 1, 1);
      step_check("p2_ok",   0, 2'b01, 2'b10, 0, 2'b10, 2'b00, 0, 2, 2, 1);

      // Randomised play against the reference model
      model(1, 0, 0, 0);
      step_check("rnd_ini", 1, 2'b00, 2'b00, 0, m_man, m_par, m_s1, m_s2, m_g, m_act);
      for (int i = 0; i < 3000; i++) begin
         logic ini;
         int p, s, c;
         ini = ($urandom_range(0, 24) == 0);
         p   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
         s   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
         c   = $urandom_range(0, 15);
         model(ini, p, s, c);
         step_check($sformatf("rnd%0d", i), ini, 2'(p), 2'(s), c,
                    m_man, m_par, m_s1, m_s2, m_g, m_act);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/morra_cinese_param.md
Name: morra_cinese_param

Overview:
Parametrised successor of the two-player Morra Cinese (rock-paper-scissors) match FSMD.
- Adds a configurable match length, win margin and minimum number of rounds, loaded through a dedicated config port.
- Adds live score, round-count and activity outputs, and a switchable no-repeat rule.
- Sits as the game-controller core; moves arrive one round per clock.

Parameters:
MIN_MANCHE, 4, minimum number of valid rounds before a lead can end the match
LEAD, 2, score difference that ends the match once MIN_MANCHE rounds have been played
CFG_W, 4, width of the cfg port; max rounds = MIN_MANCHE + cfg
CNT_W, 5, width of the counters; must hold MIN_MANCHE + 2^CFG_W - 1
NO_REPEAT, 1, 1 = the previous round's winner may not replay their winning move

Ports:
clk  in  1  clock, all state on rising edge
inizia  in  1  synchronous active-high reset / new-match start
primo  in  2  player 1 move: 00 invalid, 01 sasso, 10 carta, 11 forbice
secondo  in  2  player 2 move, same encoding
cfg  in  CFG_W  extra rounds beyond MIN_MANCHE, sampled only when inizia=1
manche  out  2  last round result: 00 invalid/none, 01 p1, 10 p2, 11 draw
partita  out  2  match result: 00 in progress, 01 p1, 10 p2, 11 draw
punti1  out  CNT_W  p1 rounds won
punti2  out  CNT_W  p2 rounds won
giocate  out  CNT_W  valid rounds played
attivo  out  1  1 while in GIOCO

Behaviour:
- Interface: one clock; reset is synchronous and active-high. The clock port is clk; the reset port is inizia. All outputs are registered.
- States: IDLE, GIOCO, FINE. State is undefined until the first inizia; benches must assert inizia first.
- inizia=1 at an edge, from any state, including mid-match:
  - state<=GIOCO; max<=MIN_MANCHE+cfg.
  - punti1, punti2, giocate <= 0; manche, partita <= 00; attivo<=1; winner memory cleared.
  - primo/secondo are ignored in that cycle.
- IDLE: moves ignored; all outputs 0.
- GIOCO, inizia=0: evaluate one round per edge; results are visible after that same edge (latency 1).
- A round is invalid if:
  - primo==00 or secondo==00; or
  - NO_REPEAT=1 and the previous round's winner plays the same move they won with.
- Invalid round: manche<=00; counters, winner memory and partita unchanged.
- Valid round:
  - Winning pairs: sasso beats forbice, carta beats sasso, forbice beats carta; equal moves = draw (11).
  - giocate++; winner's punti++.
  - Winner memory <= {winner, winning move}; a draw clears the memory.
- End-of-match check on the updated values, in the same edge:
  - If giocate>=MIN_MANCHE and |punti1-punti2|>=LEAD, partita <= the leader.
  - Else if giocate==max, partita <= the higher score, or 11 if scores are equal.
  - On either end condition: state<=FINE, attivo<=0. manche shows the final round's result in that cycle.
- A lead of LEAD or more before MIN_MANCHE rounds does not end the match.
- FINE:
  - Moves ignored; manche<=00.
  - partita, punti*, giocate held until inizia.
- Counters never wrap, because the CNT_W constraint guarantees headroom.

Test Plan (defaults):
1. Win by lead with no-repeat:
   - inizia, cfg=0.
   - Rounds (primo v secondo): 01v11 (manche 01); 01v11 again (manche 00, p1 repeat, counters unchanged); 10v01; 01v11; 10v01.
   - Required: manche=01 each valid round; after the last round punti1=4, punti2=0, giocate=4, partita=01, attivo=0.
2. All-draw match:
   - inizia, cfg=3 (max 7); 7 rounds of 10v10.
   - Required: manche=11 each round; partita=00 through round 6.
   - After round 7: giocate=7, punti 0/0, partita=11.
3. Max rounds reached with lead below LEAD:
   - inizia, cfg=1 (max 5).
   - Rounds: 01v11 (p1), 10v11 (p2), 10v01 (p1), 01v10 (p2), 01v11 (p1).
   - Required: after round 4, 2-2 and partita=00. After round 5: punti1=3, punti2=2, giocate=5, partita=01.
4. Invalid moves:
   - Mid-match 00v00, then 01v00.
   - Required: manche=00 both cycles; punti*, giocate and partita unchanged.
5. Restart mid-match:
   - After 2 valid rounds, assert inizia with cfg=2.
   - Required next cycle: all counters 0, manche=partita=00, attivo=1, max=6. A previous winner's move is allowed again.
6. FINE hold:
   - After test 1 ends, apply 10v01 for 3 cycles.
   - Required: manche=00, partita=01, punti1=4 held, attivo=0. Then inizia returns attivo to 1 with all counters 0.
